// File: rtl/lb_pxl_win_cnt_pkg.sv
// ============================================================================
//  Module   : lb_pkg
//  Brief    : Shared types and default widths for the pixel window counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package lb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_COL_W = 5;
    localparam int c_ROW_W = 5;
    localparam int c_CH_W  = 3;
    localparam int c_K     = 5;

endpackage

`default_nettype wire

// File: rtl/lb_pxl_win_cnt_cnt_up_wrap.sv
// ============================================================================
//  Module   : cnt_up_wrap
//  Brief    : Clearable up-counter that wraps at a programmable maximum.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cnt_up_wrap #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;

    // Wrap is qualified by enable so it can directly drive the next stage's enable.
    assign wrap_o = en_i && (cnt_q == max_i);
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= wrap_o ? '0 : cnt_q + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/lb_pxl_win_cnt.sv
// ============================================================================
//  Module   : lb_pxl_win_cnt
//  Brief    : Column/row/channel pixel counter with window-valid and done pulse.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lb_pxl_win_cnt
    import lb_pkg::*;
#(
    parameter int COL_W = c_COL_W,
    parameter int ROW_W = c_ROW_W,
    parameter int CH_W  = c_CH_W,
    parameter int K     = c_K
) (
    input  logic             cnt_clk,
    input  logic             cnt_rst,
    input  logic             cnt_start,
    input  logic             cnt_auto,
    input  logic [COL_W-1:0] cfg_cols_m1,
    input  logic [ROW_W-1:0] cfg_rows_m1,
    input  logic [CH_W-1:0]  cfg_chans_m1,
    input  logic             cnt_en,
    output logic [COL_W-1:0] col_idx,
    output logic [ROW_W-1:0] row_idx,
    output logic [CH_W-1:0]  ch_idx,
    output logic             col_last,
    output logic             row_last,
    output logic             win_vld,
    output logic             busy,
    output logic             cnt_done_o
);

    localparam logic [COL_W-1:0] c_K_M1_COL = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] c_K_M1_ROW = ROW_W'(K - 1);

    state_t           state_q;
    logic [COL_W-1:0] cols_m1_q;
    logic [ROW_W-1:0] rows_m1_q;
    logic [CH_W-1:0]  chans_m1_q;
    logic             done_q;

    logic w_run;
    logic w_start;
    logic w_col_wrap;
    logic w_row_wrap;
    logic w_ch_wrap;

    assign w_run   = (state_q == ST_RUN);
    assign w_start = (state_q == ST_IDLE) && cnt_start;

    cnt_up_wrap #(.W(COL_W)) u_col (
        .clk_i  (cnt_clk),
        .rst_i  (cnt_rst),
        .clr_i  (w_start),
        .en_i   (w_run && cnt_en),
        .max_i  (cols_m1_q),
        .cnt_o  (col_idx),
        .wrap_o (w_col_wrap)
    );

    cnt_up_wrap #(.W(ROW_W)) u_row (
        .clk_i  (cnt_clk),
        .rst_i  (cnt_rst),
        .clr_i  (w_start),
        .en_i   (w_col_wrap),
        .max_i  (rows_m1_q),
        .cnt_o  (row_idx),
        .wrap_o (w_row_wrap)
    );

    // Channel wrap marks the final pixel of the frame; all three counters return to 0 together.
    cnt_up_wrap #(.W(CH_W)) u_ch (
        .clk_i  (cnt_clk),
        .rst_i  (cnt_rst),
        .clr_i  (w_start),
        .en_i   (w_row_wrap),
        .max_i  (chans_m1_q),
        .cnt_o  (ch_idx),
        .wrap_o (w_ch_wrap)
    );

    always_ff @(posedge cnt_clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            state_q    <= ST_IDLE;
            cols_m1_q  <= '0;
            rows_m1_q  <= '0;
            chans_m1_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cnt_start) begin
                        cols_m1_q  <= cfg_cols_m1;
                        rows_m1_q  <= cfg_rows_m1;
                        chans_m1_q <= cfg_chans_m1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_ch_wrap) begin
                        done_q <= 1'b1;
                        if (!cnt_auto) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = w_run;
    assign cnt_done_o = done_q;
    assign col_last   = w_run && (col_idx == cols_m1_q);
    assign row_last   = col_last && (row_idx == rows_m1_q);
    assign win_vld    = w_run && (row_idx >= c_K_M1_ROW) && (col_idx >= c_K_M1_COL);

endmodule

`default_nettype wire

// File: tb/tb_lb_pxl_win_cnt.sv
// ============================================================================
//  Module   : tb_lb_pxl_win_cnt
//  Brief    : Randomized self-checking bench against a pixel-number reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lb_pxl_win_cnt;

    localparam int COL_W = 5;
    localparam int ROW_W = 5;
    localparam int CH_W  = 3;
    localparam int K     = 5;

    logic             cnt_clk = 1'b0;
    logic             cnt_rst;
    logic             cnt_start;
    logic             cnt_auto;
    logic [COL_W-1:0] cfg_cols_m1;
    logic [ROW_W-1:0] cfg_rows_m1;
    logic [CH_W-1:0]  cfg_chans_m1;
    logic             cnt_en;
    logic [COL_W-1:0] col_idx;
    logic [ROW_W-1:0] row_idx;
    logic [CH_W-1:0]  ch_idx;
    logic             col_last;
    logic             row_last;
    logic             win_vld;
    logic             busy;
    logic             cnt_done_o;

    lb_pxl_win_cnt #(.COL_W(COL_W), .ROW_W(ROW_W), .CH_W(CH_W), .K(K)) dut (
        .cnt_clk      (cnt_clk),
        .cnt_rst      (cnt_rst),
        .cnt_start    (cnt_start),
        .cnt_auto     (cnt_auto),
        .cfg_cols_m1  (cfg_cols_m1),
        .cfg_rows_m1  (cfg_rows_m1),
        .cfg_chans_m1 (cfg_chans_m1),
        .cnt_en       (cnt_en),
        .col_idx      (col_idx),
        .row_idx      (row_idx),
        .ch_idx       (ch_idx),
        .col_last     (col_last),
        .row_last     (row_last),
        .win_vld      (win_vld),
        .busy         (busy),
        .cnt_done_o   (cnt_done_o)
    );

    always #5 cnt_clk = ~cnt_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase (0 idle, 1 run, 2 done), linear pixel number within the frame.
    int m_st   = 0;
    int m_p    = 0;
    int m_cols = 1;
    int m_rows = 1;
    int m_chans = 1;
    bit m_done = 1'b0;

    int acc, dones, wins, first_win;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit b;
        int c, r, h;
        b = (m_st == 1);
        c = b ? (m_p % m_cols) : 0;
        r = b ? ((m_p / m_cols) % m_rows) : 0;
        h = b ? (m_p / (m_cols * m_rows)) : 0;
        chk("busy",     32'(busy),       32'(b));
        chk("col_idx",  32'(col_idx),    c);
        chk("row_idx",  32'(row_idx),    r);
        chk("ch_idx",   32'(ch_idx),     h);
        chk("col_last", 32'(col_last),   32'(b && c == m_cols - 1));
        chk("row_last", 32'(row_last),   32'(b && c == m_cols - 1 && r == m_rows - 1));
        chk("win_vld",  32'(win_vld),    32'(b && r >= K - 1 && c >= K - 1));
        chk("done",     32'(cnt_done_o), 32'(m_done));
    endtask

    task automatic tick();
        int nst, np;
        bit nd;
        nst = m_st;
        np  = m_p;
        nd  = 1'b0;
        if (m_st == 0) begin
            if (cnt_start) begin
                m_cols  = int'(cfg_cols_m1) + 1;
                m_rows  = int'(cfg_rows_m1) + 1;
                m_chans = int'(cfg_chans_m1) + 1;
                nst = 1;
                np  = 0;
            end
        end else if (m_st == 1) begin
            if (cnt_en) begin
                acc++;
                if (win_vld) begin
                    wins++;
                    if (first_win == 0) first_win = acc;
                end
                if (m_p == m_cols * m_rows * m_chans - 1) begin
                    nd = 1'b1;
                    np = 0;
                    if (!cnt_auto) nst = 2;
                end else begin
                    np = m_p + 1;
                end
            end
        end else begin
            nst = 0;
        end
        @(posedge cnt_clk);
        m_st   = nst;
        m_p    = np;
        m_done = nd;
        #1;
        if (cnt_done_o) dones++;
        check_all();
    endtask

    task automatic run_frame(input string name, input int cm1, input int rm1, input int chm1,
                             input int auto_dones, input bit rand_en, input bit noise,
                             input int exp_acc, input int exp_dones, input int exp_wins,
                             input int exp_first);
        int budget;
        acc = 0; dones = 0; wins = 0; first_win = 0;
        cfg_cols_m1  = COL_W'(cm1);
        cfg_rows_m1  = ROW_W'(rm1);
        cfg_chans_m1 = CH_W'(chm1);
        cnt_auto  = (auto_dones > 0);
        cnt_en    = 1'b0;
        cnt_start = 1'b1;
        tick();
        cnt_start = 1'b0;
        budget = 0;
        while (m_st != 0 && budget < 5000) begin
            cnt_en   = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            cnt_auto = (dones < auto_dones);
            cnt_start = 1'b0;
            if (noise && m_st == 1) begin
                cnt_start    = 1'($urandom_range(0, 1));
                cfg_cols_m1  = COL_W'($urandom);
                cfg_rows_m1  = ROW_W'($urandom);
                cfg_chans_m1 = CH_W'($urandom);
            end
            tick();
            budget++;
        end
        cnt_start = 1'b0;
        cnt_en    = 1'b0;
        cnt_auto  = 1'b0;
        if (m_st != 0) begin
            checks++;
            errors++;
            $error("FAIL %s.timeout observed=busy expected=idle", name);
        end
        chk({name, ".accepts"},   acc,       exp_acc);
        chk({name, ".dones"},     dones,     exp_dones);
        chk({name, ".win_count"}, wins,      exp_wins);
        chk({name, ".first_win"}, first_win, exp_first);
    endtask

    task automatic apply_reset();
        cnt_rst = 1'b1;
        #1;
        m_st = 0; m_p = 0; m_done = 1'b0; m_cols = 1; m_rows = 1; m_chans = 1;
        check_all();
        @(posedge cnt_clk);
        #1;
        check_all();
        cnt_rst = 1'b0;
        tick();
    endtask

    initial begin
        cnt_rst = 1'b1;
        cnt_start = 1'b0;
        cnt_auto = 1'b0;
        cnt_en = 1'b0;
        cfg_cols_m1 = '0;
        cfg_rows_m1 = '0;
        cfg_chans_m1 = '0;
        repeat (2) @(posedge cnt_clk);
        #1;
        check_all();
        cnt_rst = 1'b0;
        tick();

        // Abort a frame partway through with reset.
        acc = 0; dones = 0; wins = 0; first_win = 0;
        cfg_cols_m1 = 5'd7; cfg_rows_m1 = 5'd7; cfg_chans_m1 = 3'd0;
        cnt_start = 1'b1;
        tick();
        cnt_start = 1'b0;
        cnt_en = 1'b1;
        repeat (20) tick();
        cnt_en = 1'b1;
        apply_reset();
        cnt_en = 1'b0;
        chk("midreset.dones", dones, 0);
        chk("midreset.accepts", acc, 20);

        run_frame("full28", 27, 27, 0, 0, 1'b0, 1'b0, 784, 1, 576, 117);
        run_frame("multich", 3, 2, 2, 0, 1'b1, 1'b1, 36, 1, 0, 0);
        run_frame("auto", 1, 1, 0, 3, 1'b1, 1'b0, 16, 4, 0, 0);
        run_frame("single", 0, 0, 0, 0, 1'b0, 1'b0, 1, 1, 0, 0);
        run_frame("narrow", 2, 31, 0, 0, 1'b1, 1'b0, 96, 1, 0, 0);
        run_frame("ch8win", 5, 5, 7, 0, 1'b1, 1'b1, 288, 1, 32, 29);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
